// File: rtl/pocket_bridge_pkg.sv
// Shared definitions for the Pocket APF bridge SPI receiver: FSM encoding,
// frame geometry and the 2-bit symbol shift helper.
package pocket_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RTURN = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int SYM_W       = 2;
  localparam int WORD_W      = 32;
  localparam int ADDR_SYMS   = WORD_W / SYM_W;
  localparam int DATA_SYMS   = WORD_W / SYM_W;
  localparam int WR_FLAG_BIT = 0;

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_SYMS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_SYMS - 1);

  // MSB-first: the newest symbol lands in the low bits.
  function automatic logic [WORD_W-1:0] shift_sym(input logic [WORD_W-1:0] w,
                                                  input logic [SYM_W-1:0]  s);
    return {w[WORD_W-SYM_W-1:0], s};
  endfunction

endpackage

// File: rtl/pocket_bridge_rx_if.sv
// Register-bus side of the bridge: one strobe per frame, read data returned with ack.
interface pocket_bridge_rx_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_wr, bus_rd,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_wr, bus_rd,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/pocket_bridge_sync.sv
// Pad synchronisers for spi_clk/spi_ss/spi_din plus one-clk edge pulses
// for spi_clk and spi_ss, all taken from the synchronised copies.
module pocket_bridge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_ss,
  input  logic [1:0] spi_din,
  output logic       ss,
  output logic [1:0] din,
  output logic       clk_rise,
  output logic       clk_fall,
  output logic       ss_rise,
  output logic       ss_fall
);

  localparam int PINS = 4;

  logic [PINS-1:0]                  pin;
  logic [PINS-1:0][SYNC_STAGES-1:0] chain;
  logic [PINS-1:0]                  synced;
  logic                             sclk;
  logic                             sclk_q;
  logic                             ss_q;

  assign pin = {spi_clk, spi_ss, spi_din};

  // Chains clear to 0, so ss reads as asserted out of reset: a frame can only
  // begin after ss has been seen high and then falls again.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      for (int p = 0; p < PINS; p++)
        chain[p] <= {chain[p][SYNC_STAGES-2:0], pin[p]};
    end
  end

  for (genvar p = 0; p < PINS; p++) begin : g_pin
    assign synced[p] = chain[p][SYNC_STAGES-1];
  end

  assign sclk = synced[3];
  assign ss   = synced[2];
  assign din  = synced[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      ss_q   <= 1'b0;
    end else begin
      sclk_q <= sclk;
      ss_q   <= ss;
    end
  end

  assign clk_rise = sclk & ~sclk_q;
  assign clk_fall = ~sclk & sclk_q;
  assign ss_rise  = ss & ~ss_q;
  assign ss_fall  = ~ss & ss_q;

endmodule

// File: rtl/pocket_bridge_rx.sv
// Core-side slave of the Pocket bridge SPI link: turns each ss-low frame into
// one register-bus write or read, shifting read data back out MSB first.
module pocket_bridge_rx
  import pocket_bridge_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RD_DEFAULT  = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_clk,
  input  logic                      spi_ss,
  input  logic [1:0]                spi_din,
  output logic [1:0]                spi_dout,
  output logic                      spi_oe,
  pocket_bridge_rx_if.master        bus,
  output logic                      busy
);

  logic        ss;
  logic [1:0]  din;
  logic        clk_rise;
  logic        clk_fall;
  logic        ss_rise;
  logic        ss_fall;

  state_e      state;
  state_e      state_n;
  logic [3:0]  bit_cnt;
  logic [31:0] shreg;
  logic [31:0] shreg_n;
  logic [31:0] rd_hold;
  logic        rd_got;
  logic [31:0] rd_word;

  logic        sh_in;
  logic        cnt_inc;
  logic        cnt_clr;
  logic        addr_ld;
  logic        wdata_ld;
  logic        rd_stb;
  logic        wr_stb;
  logic        out_ld;
  logic        out_sh;
  logic        oe_off;

  pocket_bridge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .spi_ss   (spi_ss),
    .spi_din  (spi_din),
    .ss       (ss),
    .din      (din),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall)
  );

  assign shreg_n = shift_sym(shreg, din);
  assign rd_word = rd_got ? rd_hold : RD_DEFAULT;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    sh_in    = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    addr_ld  = 1'b0;
    wdata_ld = 1'b0;
    rd_stb   = 1'b0;
    wr_stb   = 1'b0;
    out_ld   = 1'b0;
    out_sh   = 1'b0;
    oe_off   = 1'b0;

    // ss rising wins over any spi_clk edge in the same cycle.
    if (state != S_IDLE && ss_rise) begin
      state_n = S_IDLE;
      oe_off  = 1'b1;
      cnt_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (ss_fall) begin
            state_n = S_ADDR;
            cnt_clr = 1'b1;
          end
        end
        S_ADDR: begin
          if (clk_rise) begin
            sh_in = 1'b1;
            if (bit_cnt == ADDR_LAST) begin
              addr_ld = 1'b1;
              cnt_clr = 1'b1;
              if (shreg_n[WR_FLAG_BIT]) begin
                state_n = S_WDATA;
              end else begin
                rd_stb  = 1'b1;
                state_n = S_RTURN;
              end
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (clk_rise) begin
            sh_in = 1'b1;
            if (bit_cnt == DATA_LAST) begin
              wdata_ld = 1'b1;
              wr_stb   = 1'b1;
              cnt_clr  = 1'b1;
              state_n  = S_DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        S_RTURN: begin
          if (clk_fall) begin
            out_ld  = 1'b1;
            cnt_clr = 1'b1;
            state_n = S_RDATA;
          end
        end
        S_RDATA: begin
          // bit_cnt indexes the symbol currently on the pins.
          if (clk_fall) begin
            if (bit_cnt == DATA_LAST) begin
              oe_off  = 1'b1;
              cnt_clr = 1'b1;
              state_n = S_DONE;
            end else begin
              out_sh  = 1'b1;
              cnt_inc = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (ss) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= '0;
      shreg         <= '0;
      rd_hold       <= '0;
      rd_got        <= 1'b0;
      spi_dout      <= '0;
      spi_oe        <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wr    <= 1'b0;
      bus.bus_rd    <= 1'b0;
    end else begin
      bus.bus_wr <= wr_stb;
      bus.bus_rd <= rd_stb;

      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;

      if (sh_in)    shreg         <= shreg_n;
      if (addr_ld)  bus.bus_addr  <= shreg_n;
      if (wdata_ld) bus.bus_wdata <= shreg_n;

      // Only the first ack inside the turnaround window counts.
      if (rd_stb) begin
        rd_got <= 1'b0;
      end else if (state == S_RTURN && bus.bus_ack && !rd_got) begin
        rd_hold <= bus.bus_rdata;
        rd_got  <= 1'b1;
      end

      if (out_ld) begin
        spi_oe   <= 1'b1;
        spi_dout <= rd_word[31:30];
        shreg    <= {rd_word[29:0], 2'b00};
      end else if (out_sh) begin
        spi_dout <= shreg[31:30];
        shreg    <= {shreg[29:0], 2'b00};
      end

      if (oe_off) begin
        spi_oe   <= 1'b0;
        spi_dout <= '0;
      end
    end
  end

endmodule
